aibcr3_dcc_req_ctrl: RTL and testbench
======================================

Name: aibcr3_dcc_req_ctrl

Overview:
- Core-side initiator of the DCC calibration handshake. It drives dcc_req toward the DCC/DLL block and consumes that block's dcc_done.
- Runs a four-phase req/done handshake with timeout, bounded retry and stop/abort.
- Snapshots the 13-bit odll_dll2core status word when calibration completes.
- Sits in the core clock domain. dcc_done arrives asynchronously and is synchronized internally.

Parameters:
- TMO_CYC, 4096: cycles allowed in WAIT_DONE before a timeout; legal range 2..65535.
- RETRY_MAX, 3: number of retries after the first attempt before FAIL; legal range 0..15.
- GAP_CYC, 8: minimum cycles dcc_req is held low between attempts; legal range 1..255.
- SYNC_STG, 2: synchronizer depth for dcc_done; legal range 2..3.

Ports:
- clk  in  1  core clock
- nrst  in  1  reset, synchronous, active-low
- cal_start  in  1  pulse or level; a calibration starts when it is sampled high in IDLE, LOCKED or FAIL
- cal_stop  in  1  abort or release request; level-sensitive
- dcc_done  in  1  asynchronous done from the DCC block
- odll_dll2core  in  13  DLL status/code word from the DCC block
- dcc_req  out  1  request to the DCC block; registered
- cal_busy  out  1  high in REQ, WAIT_DONE, DROP and GAP
- cal_locked  out  1  high in LOCKED
- cal_fail  out  1  high in FAIL
- cal_attempt  out  4  index of the current or last attempt, counted from 0
- dcc_code_snap  out  13  odll_dll2core captured at lock

Behaviour:
- Reset (nrst sampled low at a clk edge): state=IDLE, dcc_req=0, cal_busy=0, cal_locked=0, cal_fail=0, cal_attempt=0, dcc_code_snap=0, synchronizer flops=0, counters=0.
- done_s is dcc_done after SYNC_STG flops, giving SYNC_STG cycles of latency. The FSM uses only done_s.
- IDLE: if cal_start=1, go to REQ, set cal_attempt=0, set dcc_req=1 on the next edge.
- REQ: one cycle with dcc_req=1. Clear tmo_cnt to 0, then go to WAIT_DONE.
- WAIT_DONE: dcc_req=1 and tmo_cnt increments each cycle. Evaluate in this priority order:
  1. cal_stop=1: go to DROP, set abort flag.
  2. done_s=1: capture odll_dll2core into dcc_code_snap in this cycle, go to LOCKED. Done wins over a timeout in the same cycle.
  3. tmo_cnt=TMO_CYC-1: timeout. Go to DROP and set the retry flag.
- LOCKED: dcc_req stays 1 (a held lock), cal_locked=1.
  - cal_stop=1: go to DROP; on its exit go to IDLE.
  - cal_start=1 with cal_stop=0: recalibration. Go to DROP, then GAP, then REQ with cal_attempt=0.
- DROP: dcc_req=0 from the entry edge onward. Wait for done_s=0, with no timeout. Then go to GAP and clear gap_cnt.
- GAP: dcc_req=0. gap_cnt counts up to GAP_CYC-1. On exit, in priority order:
  1. Abort or stop set: go to IDLE.
  2. Retry flag set and cal_attempt=RETRY_MAX: go to FAIL.
  3. Retry flag set: cal_attempt+1, go to REQ.
  4. Recalibration: go to REQ.
- FAIL: dcc_req=0, cal_fail=1. Held until cal_start=1 with cal_stop=0, which goes to GAP and then REQ with cal_attempt=0. cal_fail clears on leaving FAIL.
- cal_start and cal_stop high in the same cycle: cal_stop wins.
- cal_start while busy: ignored.
- dcc_done high while in IDLE: ignored; REQ is still entered when started.
- Counters never wrap:
  - tmo_cnt is 16 bits and saturates.
  - gap_cnt is 8 bits.
  - cal_attempt never exceeds RETRY_MAX.
- dcc_code_snap is held until the next successful lock or reset.
- Reset mid-handshake: dcc_req=0 on the next edge. The DCC block observes a req fall and releases independently.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: DCC_PERIODIC_RECAL_EN.
- When defined:
  - Adds input recal_interval[15:0] and a 16-bit counter that runs only in LOCKED.
  - When the counter reaches recal_interval, a recalibration starts, identical to cal_start in LOCKED.
  - recal_interval=0 disables this.
  - The counter clears on entry to LOCKED and on any recalibration.
- When undefined: no port, no counter, and only cal_start triggers recalibration.

Test Plan:
- Nominal: reset, cal_start pulse, dcc_done high 20 cycles after dcc_req rises, odll_dll2core=13'h1A5 -> cal_locked=1 at req-rise + 20 + SYNC_STG + 1 cycles, dcc_code_snap=13'h1A5, cal_attempt=0, dcc_req stays 1.
- Timeout with retry: TMO_CYC=16, RETRY_MAX=2, dcc_done held 0 -> three req pulses, each 17 cycles high (1 REQ + 16 WAIT_DONE), separated by at least 8 low cycles; cal_attempt goes 0,1,2; then cal_fail=1, dcc_req=0.
- Late done: dcc_done rises on the exact timeout cycle -> the lock is taken (done wins), cal_locked=1, no retry.
- Stop mid-wait: cal_stop asserted 5 cycles into WAIT_DONE while dcc_done=1 sticks for 10 more cycles -> dcc_req=0 next cycle, state stays in DROP until done_s=0, then at least GAP_CYC cycles, then IDLE with cal_busy=0.
- Recalibration from LOCKED: cal_start while locked -> dcc_req falls, waits for done to fall, GAP, re-rises; the new snapshot replaces the old value.
- Reset mid-WAIT_DONE: nrst low for 1 cycle -> all outputs at reset values on the following edge; the next cal_start begins at cal_attempt=0.

Source files
------------

// File: rtl/aibcr3_dcc_req_ctrl.sv
// Core-side initiator of the DCC calibration req/done handshake with timeout, retry and abort.
// Optional periodic recalibration from LOCKED is enabled by defining DCC_PERIODIC_RECAL_EN.
module aibcr3_dcc_req_ctrl #(
    parameter int unsigned TMO_CYC   = 4096,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned GAP_CYC   = 8,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cal_start,
    input  logic        cal_stop,
    input  logic        dcc_done,
    input  logic [12:0] odll_dll2core,
`ifdef DCC_PERIODIC_RECAL_EN
    input  logic [15:0] recal_interval,
`endif
    output logic        dcc_req,
    output logic        cal_busy,
    output logic        cal_locked,
    output logic        cal_fail,
    output logic [3:0]  cal_attempt,
    output logic [12:0] dcc_code_snap
);

    typedef enum logic [2:0] {
        StIdle, StReq, StWait, StLocked, StDrop, StGap, StFail
    } state_e;

    localparam logic [15:0] TmoLast  = 16'(TMO_CYC - 1);
    localparam logic [7:0]  GapLast  = 8'(GAP_CYC - 1);
    localparam logic [3:0]  RetryMax = 4'(RETRY_MAX);

    state_e              state_q, state_d;
    logic [SYNC_STG-1:0] sync_q;
    logic                done_s;
    logic [15:0]         tmo_q, tmo_d;
    logic [7:0]          gap_q, gap_d;
    logic [3:0]          attempt_q, attempt_d;
    logic                abort_q, abort_d;
    logic                retry_q, retry_d;
    logic [12:0]         snap_q, snap_d;
    logic                req_q, busy_q, locked_q, fail_q;
    logic                recal_hit;

    assign done_s = sync_q[SYNC_STG-1];

`ifdef DCC_PERIODIC_RECAL_EN
    logic [15:0] recal_cnt_q, recal_cnt_d;
    assign recal_hit = (recal_interval != 16'd0) && (recal_cnt_q == recal_interval);
`else
    assign recal_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        attempt_d = attempt_q;
        abort_d   = abort_q;
        retry_d   = retry_q;
        snap_d    = snap_q;
`ifdef DCC_PERIODIC_RECAL_EN
        recal_cnt_d = recal_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (cal_start && !cal_stop) begin
                    state_d   = StReq;
                    attempt_d = 4'd0;
                    abort_d   = 1'b0;
                    retry_d   = 1'b0;
                end
            end
            StReq: begin
                tmo_d   = 16'd0;
                state_d = StWait;
            end
            StWait: begin
                if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
                // Stop beats done, done beats a coincident timeout.
                if (cal_stop) begin
                    state_d = StDrop;
                    abort_d = 1'b1;
                end else if (done_s) begin
                    snap_d  = odll_dll2core;
                    state_d = StLocked;
`ifdef DCC_PERIODIC_RECAL_EN
                    recal_cnt_d = 16'd0;
`endif
                end else if (tmo_q == TmoLast) begin
                    state_d = StDrop;
                    retry_d = 1'b1;
                end
            end
            StLocked: begin
`ifdef DCC_PERIODIC_RECAL_EN
                if (recal_cnt_q != 16'hFFFF) recal_cnt_d = recal_cnt_q + 16'd1;
`endif
                if (cal_stop) begin
                    state_d = StDrop;
                    abort_d = 1'b1;
                end else if (cal_start || recal_hit) begin
                    state_d   = StDrop;
                    attempt_d = 4'd0;
                    retry_d   = 1'b0;
`ifdef DCC_PERIODIC_RECAL_EN
                    recal_cnt_d = 16'd0;
`endif
                end
            end
            StDrop: begin
                if (!done_s) begin
                    state_d = StGap;
                    gap_d   = 8'd0;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    if (abort_q || cal_stop) begin
                        state_d = StIdle;
                    end else if (retry_q && attempt_q == RetryMax) begin
                        state_d = StFail;
                    end else begin
                        if (retry_q) attempt_d = attempt_q + 4'd1;
                        state_d = StReq;
                        abort_d = 1'b0;
                        retry_d = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            StFail: begin
                if (cal_start && !cal_stop) begin
                    state_d   = StGap;
                    gap_d     = 8'd0;
                    attempt_d = 4'd0;
                    abort_d   = 1'b0;
                    retry_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= StIdle;
            sync_q    <= '0;
            tmo_q     <= 16'd0;
            gap_q     <= 8'd0;
            attempt_q <= 4'd0;
            abort_q   <= 1'b0;
            retry_q   <= 1'b0;
            snap_q    <= 13'd0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
`ifdef DCC_PERIODIC_RECAL_EN
            recal_cnt_q <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[SYNC_STG-2:0], dcc_done};
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            attempt_q <= attempt_d;
            abort_q   <= abort_d;
            retry_q   <= retry_d;
            snap_q    <= snap_d;
            req_q     <= state_d inside {StReq, StWait, StLocked};
            busy_q    <= state_d inside {StReq, StWait, StDrop, StGap};
            locked_q  <= (state_d == StLocked);
            fail_q    <= (state_d == StFail);
`ifdef DCC_PERIODIC_RECAL_EN
            recal_cnt_q <= recal_cnt_d;
`endif
        end
    end

    assign dcc_req       = req_q;
    assign cal_busy      = busy_q;
    assign cal_locked    = locked_q;
    assign cal_fail      = fail_q;
    assign cal_attempt   = attempt_q;
    assign dcc_code_snap = snap_q;

endmodule

// File: tb/tb_aibcr3_dcc_req_ctrl.sv
// Directed plus randomized bench for aibcr3_dcc_req_ctrl; expected edge times come from
// closed-form handshake timing (latency, timeout width, gap length) rather than a state model.
module tb_aibcr3_dcc_req_ctrl;

    localparam int unsigned TMO  = 24;
    localparam int unsigned RMAX = 2;
    localparam int unsigned GAP  = 8;
    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cal_start = 1'b0;
    logic        cal_stop = 1'b0;
    logic        dcc_done = 1'b0;
    logic [12:0] odll = 13'd0;
    logic        dcc_req, cal_busy, cal_locked, cal_fail;
    logic [3:0]  cal_attempt;
    logic [12:0] dcc_code_snap;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    aibcr3_dcc_req_ctrl #(
        .TMO_CYC  (TMO),
        .RETRY_MAX(RMAX),
        .GAP_CYC  (GAP),
        .SYNC_STG (SYNC)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .cal_start    (cal_start),
        .cal_stop     (cal_stop),
        .dcc_done     (dcc_done),
        .odll_dll2core(odll),
        .dcc_req      (dcc_req),
        .cal_busy     (cal_busy),
        .cal_locked   (cal_locked),
        .cal_fail     (cal_fail),
        .cal_attempt  (cal_attempt),
        .dcc_code_snap(dcc_code_snap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return dcc_req;
            1: return cal_locked;
            2: return cal_busy;
            3: return cal_fail;
            default: return 1'bx;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input string tag, output int at);
        bit got;
        got = (sig(sel) === val);
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            got = (sig(sel) === val);
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        at = cyc;
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Edge at which GAP completes after DROP entered at edge s, done lowered after edge l.
    function automatic int drop_exit(input int s, input int l);
        return max2(s + 1, l + int'(SYNC) + 1) + int'(GAP);
    endfunction

    task automatic start_cal(output int s);
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        s = cyc;
    endtask

    task automatic release_lock(input string tag);
        int s, t;
        cal_stop = 1'b1;
        dcc_done = 1'b0;
        step();
        s = cyc;
        chk({tag, "_req_drop"}, 32'(dcc_req), 32'd0);
        wait_sig(2, 1'b0, {tag, "_idle"}, t);
        chk({tag, "_idle_edge"}, 32'(t), 32'(drop_exit(s, s - 1)));
        cal_stop = 1'b0;
        step();
    endtask

    initial begin
        int s, r, r2, f, l, t, ld, k, d;
        logic [12:0] code;
        bit from_fail;

        // Reset state
        repeat (3) step();
        chk("rst_req", 32'(dcc_req), 32'd0);
        chk("rst_busy", 32'(cal_busy), 32'd0);
        chk("rst_locked", 32'(cal_locked), 32'd0);
        chk("rst_fail", 32'(cal_fail), 32'd0);
        chk("rst_attempt", 32'(cal_attempt), 32'd0);
        chk("rst_snap", 32'(dcc_code_snap), 32'd0);
        nrst = 1'b1;
        step();

        // Start+stop together is ignored; stale done in IDLE does not block the start
        dcc_done = 1'b1;
        repeat (3) step();
        cal_start = 1'b1;
        cal_stop  = 1'b1;
        step();
        cal_start = 1'b0;
        cal_stop  = 1'b0;
        step();
        chk("startstop_busy", 32'(cal_busy), 32'd0);
        chk("startstop_req", 32'(dcc_req), 32'd0);
        odll = 13'h0F0;
        start_cal(s);
        chk("stale_req", 32'(dcc_req), 32'd1);
        wait_sig(1, 1'b1, "stale_lock", l);
        chk("stale_lock_edge", 32'(l), 32'(s + 2));
        release_lock("stale_rel");

        // Nominal lock 20 cycles after req rise
        odll = 13'h1A5;
        start_cal(r);
        chk("nom_req", 32'(dcc_req), 32'd1);
        repeat (20) step();
        dcc_done = 1'b1;
        wait_sig(1, 1'b1, "nom_lock", l);
        chk("nom_lock_edge", 32'(l - r), 32'(20 + SYNC + 1));
        chk("nom_snap", 32'(dcc_code_snap), 32'h1A5);
        chk("nom_attempt", 32'(cal_attempt), 32'd0);
        chk("nom_req_held", 32'(dcc_req), 32'd1);
        chk("nom_busy", 32'(cal_busy), 32'd0);

        // Recalibration from LOCKED with done lingering high
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        s = cyc;
        chk("recal_req_drop", 32'(dcc_req), 32'd0);
        chk("recal_unlocked", 32'(cal_locked), 32'd0);
        repeat (3) step();
        dcc_done = 1'b0;
        ld = cyc;
        wait_sig(0, 1'b1, "recal_rise", r);
        chk("recal_rise_edge", 32'(r), 32'(drop_exit(s, ld)));
        chk("recal_attempt", 32'(cal_attempt), 32'd0);
        chk("recal_snap_held", 32'(dcc_code_snap), 32'h1A5);
        odll = 13'h0C3;
        repeat (5) step();
        dcc_done = 1'b1;
        wait_sig(1, 1'b1, "recal_lock", l);
        chk("recal_lock_edge", 32'(l - r), 32'(5 + SYNC + 1));
        chk("recal_snap_new", 32'(dcc_code_snap), 32'h0C3);
        release_lock("recal_rel");

        // Done seen on the exact timeout cycle: lock wins
        odll = 13'h1FFF;
        start_cal(r);
        repeat (TMO - 2) step();
        dcc_done = 1'b1;
        wait_sig(1, 1'b1, "late_lock", l);
        chk("late_lock_edge", 32'(l), 32'(r + int'(TMO) + 1));
        chk("late_attempt", 32'(cal_attempt), 32'd0);
        chk("late_snap", 32'(dcc_code_snap), 32'h1FFF);
        release_lock("late_rel");

        // Done one cycle too late: timeout, DROP waits for done to fall, retry as attempt 1
        start_cal(r);
        repeat (TMO - 1) step();
        dcc_done = 1'b1;
        wait_sig(0, 1'b0, "tooLate_fall", f);
        chk("tooLate_fall_edge", 32'(f), 32'(r + int'(TMO) + 1));
        chk("tooLate_unlocked", 32'(cal_locked), 32'd0);
        repeat (2) step();
        dcc_done = 1'b0;
        ld = cyc;
        wait_sig(0, 1'b1, "tooLate_rise", r2);
        chk("tooLate_rise_edge", 32'(r2), 32'(drop_exit(f, ld)));
        chk("tooLate_attempt", 32'(cal_attempt), 32'd1);
        step();
        cal_stop = 1'b1;
        step();
        s = cyc;
        chk("tooLate_stop_req", 32'(dcc_req), 32'd0);
        wait_sig(2, 1'b0, "tooLate_idle", t);
        chk("tooLate_idle_edge", 32'(t), 32'(drop_exit(s, ld)));
        cal_stop = 1'b0;
        step();

        // Stop mid-wait while done is stuck high
        start_cal(r);
        repeat (3) step();
        dcc_done = 1'b1;
        repeat (2) step();
        cal_stop = 1'b1;
        step();
        s = cyc;
        chk("stop_req_drop", 32'(dcc_req), 32'd0);
        chk("stop_no_lock", 32'(cal_locked), 32'd0);
        repeat (7) step();
        chk("stop_busy_in_drop", 32'(cal_busy), 32'd1);
        dcc_done = 1'b0;
        ld = cyc;
        wait_sig(2, 1'b0, "stop_idle", t);
        chk("stop_idle_edge", 32'(t), 32'(drop_exit(s, ld)));
        chk("stop_attempt", 32'(cal_attempt), 32'd0);
        cal_stop = 1'b0;
        step();

        // Reset in the middle of a retry attempt
        start_cal(r);
        wait_sig(0, 1'b0, "rstmid_fall", f);
        chk("rstmid_width", 32'(f - r), 32'(TMO + 1));
        wait_sig(0, 1'b1, "rstmid_rise", r2);
        chk("rstmid_rise_edge", 32'(r2), 32'(f + int'(GAP) + 1));
        chk("rstmid_attempt1", 32'(cal_attempt), 32'd1);
        repeat (3) step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("rstmid_req", 32'(dcc_req), 32'd0);
        chk("rstmid_busy", 32'(cal_busy), 32'd0);
        chk("rstmid_attempt", 32'(cal_attempt), 32'd0);
        chk("rstmid_snap", 32'(dcc_code_snap), 32'd0);
        start_cal(s);
        chk("rstmid_restart_req", 32'(dcc_req), 32'd1);
        chk("rstmid_restart_attempt", 32'(cal_attempt), 32'd0);
        step();
        cal_stop = 1'b1;
        step();
        s = cyc;
        wait_sig(2, 1'b0, "rstmid_idle", t);
        chk("rstmid_idle_edge", 32'(t), 32'(s + 1 + int'(GAP)));
        cal_stop = 1'b0;
        step();

        // Randomized: k timed-out attempts, then a lock after d cycles or FAIL
        from_fail = 1'b0;
        for (int it = 0; it < 8; it++) begin
            k    = int'($urandom_range(0, RMAX + 1));
            d    = int'($urandom_range(0, TMO - 2));
            code = 13'($urandom);
            odll = code;
            start_cal(s);
            if (from_fail) begin
                chk("rnd_fail_clear", 32'(cal_fail), 32'd0);
                chk("rnd_fail_busy", 32'(cal_busy), 32'd1);
            end
            r2 = from_fail ? s + int'(GAP) : s;
            for (int a = 0; a <= int'(RMAX); a++) begin
                wait_sig(0, 1'b1, "rnd_rise", r);
                chk("rnd_rise_edge", 32'(r), 32'(r2));
                chk("rnd_attempt", 32'(cal_attempt), 32'(a));
                if (a < k) begin
                    repeat (3) step();
                    cal_start = 1'b1;
                    step();
                    cal_start = 1'b0;
                    wait_sig(0, 1'b0, "rnd_fall", f);
                    chk("rnd_width", 32'(f - r), 32'(TMO + 1));
                    r2 = f + int'(GAP) + 1;
                    if (a == int'(RMAX)) begin
                        wait_sig(3, 1'b1, "rnd_fail", t);
                        chk("rnd_fail_edge", 32'(t), 32'(r2));
                        chk("rnd_fail_req", 32'(dcc_req), 32'd0);
                        chk("rnd_fail_attempt", 32'(cal_attempt), 32'(RMAX));
                        from_fail = 1'b1;
                    end
                end else begin
                    repeat (d) step();
                    dcc_done = 1'b1;
                    wait_sig(1, 1'b1, "rnd_lock", l);
                    chk("rnd_lock_edge", 32'(l - r), 32'(d + int'(SYNC) + 1));
                    chk("rnd_snap", 32'(dcc_code_snap), 32'(code));
                    release_lock("rnd_rel");
                    from_fail = 1'b0;
                    break;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
